// File: rtl/sddr_pkg.sv
// Shared types, derived line geometry and byte-merge helpers for the
// SDRAM line adapter. Geometry follows the controller's default parameters.
package sddr_pkg;

   localparam int CTRL_BANK_BITS    = 3;
   localparam int CTRL_ROW_BITS     = 13;
   localparam int CTRL_COL_BITS     = 10;
   localparam int CTRL_DATA_BITS    = 16;
   localparam int CTRL_BURST_LENGTH = 8;

   localparam int LINE_BITS     = CTRL_BURST_LENGTH * CTRL_DATA_BITS;
   localparam int LINE_BYTES    = LINE_BITS / 8;
   localparam int LINE_OFF_BITS = $clog2(LINE_BYTES);
   localparam int WORD_IDX_BITS = LINE_OFF_BITS - 2;
   localparam int ADDRESS_BITS  = CTRL_BANK_BITS + CTRL_ROW_BITS +
                                  CTRL_COL_BITS + $clog2(CTRL_DATA_BITS / 8);

   typedef logic [LINE_BITS-1:0] line_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL_REQ,
      FILL_WAIT,
      WB_REQ,
      WB_WAIT,
      RESP
   } state_t;

   // Overwrite the enabled byte lanes of one 32-bit word inside a line.
   function automatic line_t merge_word(
      input line_t                    line,
      input logic [WORD_IDX_BITS-1:0] word_idx,
      input logic [31:0]              wdata,
      input logic [3:0]               be
   );
      line_t r;
      r = line;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            r[32*word_idx + 8*b +: 8] = wdata[8*b +: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] get_word(
      input line_t                    line,
      input logic [WORD_IDX_BITS-1:0] word_idx
   );
      return line[32*word_idx +: 32];
   endfunction

endpackage

// File: rtl/sddr_line_adapter_if.sv
// CPU request/response and controller data-path bundle of the line adapter.
// master: adapter side; slave: CPU + controller side.
interface sddr_line_adapter_if #(
   parameter int ADDR_W = sddr_pkg::ADDRESS_BITS,
   parameter int LINE_W = sddr_pkg::LINE_BITS
);

   logic              cpu_req_valid;
   logic              cpu_req_ack;
   logic [ADDR_W-1:0] cpu_req_addr;
   logic              cpu_req_write;
   logic [31:0]       cpu_req_wdata;
   logic [3:0]        cpu_req_be;
   logic              cpu_rsp_valid;
   logic [31:0]       cpu_rsp_rdata;

   logic              mem_cmd_valid;
   logic              mem_cmd_ack;
   logic [ADDR_W-1:0] mem_cmd_addr;
   logic              mem_cmd_write;
   logic [LINE_W-1:0] mem_cmd_data;
   logic              mem_rsp_ready;
   logic [LINE_W-1:0] mem_rsp_data;

   modport master (
      input  cpu_req_valid, cpu_req_addr, cpu_req_write,
      input  cpu_req_wdata, cpu_req_be,
      output cpu_req_ack, cpu_rsp_valid, cpu_rsp_rdata,
      output mem_cmd_valid, mem_cmd_addr, mem_cmd_write, mem_cmd_data,
      input  mem_cmd_ack, mem_rsp_ready, mem_rsp_data
   );

   modport slave (
      output cpu_req_valid, cpu_req_addr, cpu_req_write,
      output cpu_req_wdata, cpu_req_be,
      input  cpu_req_ack, cpu_rsp_valid, cpu_rsp_rdata,
      input  mem_cmd_valid, mem_cmd_addr, mem_cmd_write, mem_cmd_data,
      output mem_cmd_ack, mem_rsp_ready, mem_rsp_data
   );

endinterface

// File: rtl/sddr_line_adapter.sv
// Single-line buffer turning 32-bit CPU accesses into burst line transfers;
// write-through with read-modify-write. Ports: cpu_clock_i, reset_i, bus.
module sddr_line_adapter
   import sddr_pkg::*;
#(
   parameter int BANK_BITS    = 3,
   parameter int ROW_BITS     = 13,
   parameter int COL_BITS     = 10,
   parameter int DATA_BITS    = 16,
   parameter int BURST_LENGTH = 8
) (
   input logic                cpu_clock_i,
   input logic                reset_i,
   sddr_line_adapter_if.master bus
);

   localparam int L_BITS   = BURST_LENGTH * DATA_BITS;
   localparam int OFF_BITS = $clog2(L_BITS / 8);
   localparam int WI_BITS  = OFF_BITS - 2;
   localparam int A_BITS   = BANK_BITS + ROW_BITS + COL_BITS +
                             $clog2(DATA_BITS / 8);
   localparam int T_BITS   = A_BITS - OFF_BITS;

   state_t              state_q, state_d;
   logic                line_valid_q, line_valid_d;
   logic [T_BITS-1:0]   line_tag_q, line_tag_d;
   logic [L_BITS-1:0]   line_data_q, line_data_d;
   logic [T_BITS-1:0]   req_tag_q, req_tag_d;
   logic [WI_BITS-1:0]  req_widx_q, req_widx_d;
   logic                req_write_q, req_write_d;
   logic [31:0]         req_wdata_q, req_wdata_d;
   logic [3:0]          req_be_q, req_be_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [A_BITS-1:0]   cmd_addr_q, cmd_addr_d;
   logic                cmd_write_q, cmd_write_d;
   logic [L_BITS-1:0]   cmd_data_q, cmd_data_d;

   logic [T_BITS-1:0]   in_tag;
   logic [WI_BITS-1:0]  in_widx;
   logic                hit;
   logic [L_BITS-1:0]   hit_merged;
   logic [L_BITS-1:0]   fill_merged;

   assign in_tag      = bus.cpu_req_addr[A_BITS-1:OFF_BITS];
   assign in_widx     = bus.cpu_req_addr[OFF_BITS-1:2];
   assign hit         = line_valid_q && (line_tag_q == in_tag);
   assign hit_merged  = merge_word(line_data_q, in_widx,
                                   bus.cpu_req_wdata, bus.cpu_req_be);
   assign fill_merged = merge_word(bus.mem_rsp_data, req_widx_q,
                                   req_wdata_q, req_be_q);

   assign bus.cpu_req_ack   = (state_q == IDLE);
   assign bus.cpu_rsp_valid = rsp_valid_q;
   assign bus.cpu_rsp_rdata = rsp_rdata_q;
   assign bus.mem_cmd_valid = cmd_valid_q;
   assign bus.mem_cmd_addr  = cmd_addr_q;
   assign bus.mem_cmd_write = cmd_write_q;
   assign bus.mem_cmd_data  = cmd_data_q;

   always_comb begin
      state_d      = state_q;
      line_valid_d = line_valid_q;
      line_tag_d   = line_tag_q;
      line_data_d  = line_data_q;
      req_tag_d    = req_tag_q;
      req_widx_d   = req_widx_q;
      req_write_d  = req_write_q;
      req_wdata_d  = req_wdata_q;
      req_be_d     = req_be_q;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = rsp_rdata_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_write_d  = cmd_write_q;
      cmd_data_d   = cmd_data_q;

      unique case (state_q)
         IDLE: begin
            if (bus.cpu_req_valid) begin
               req_tag_d   = in_tag;
               req_widx_d  = in_widx;
               req_write_d = bus.cpu_req_write;
               req_wdata_d = bus.cpu_req_wdata;
               req_be_d    = bus.cpu_req_be;
               if (bus.cpu_req_write && bus.cpu_req_be == 4'h0) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else if (!bus.cpu_req_write && hit) begin
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = get_word(line_data_q, in_widx);
               end else if (hit) begin
                  // Write-through: the merged line goes straight out.
                  line_data_d = hit_merged;
                  cmd_valid_d = 1'b1;
                  cmd_write_d = 1'b1;
                  cmd_addr_d  = {in_tag, {OFF_BITS{1'b0}}};
                  cmd_data_d  = hit_merged;
                  state_d     = WB_REQ;
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_write_d = 1'b0;
                  cmd_addr_d  = {in_tag, {OFF_BITS{1'b0}}};
                  state_d     = FILL_REQ;
               end
            end
         end
         FILL_REQ: begin
            if (bus.mem_cmd_ack) begin
               cmd_valid_d = 1'b0;
               state_d     = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            if (bus.mem_rsp_ready) begin
               line_valid_d = 1'b1;
               line_tag_d   = req_tag_q;
               if (req_write_q) begin
                  line_data_d = fill_merged;
                  cmd_valid_d = 1'b1;
                  cmd_write_d = 1'b1;
                  cmd_data_d  = fill_merged;
                  state_d     = WB_REQ;
               end else begin
                  line_data_d = bus.mem_rsp_data;
                  state_d     = RESP;
               end
            end
         end
         WB_REQ: begin
            if (bus.mem_cmd_ack) begin
               cmd_valid_d = 1'b0;
               state_d     = WB_WAIT;
            end
         end
         WB_WAIT: begin
            if (bus.mem_rsp_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = get_word(line_data_q, req_widx_q);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cpu_clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         line_valid_q <= 1'b0;
         line_tag_q   <= '0;
         line_data_q  <= '0;
         req_tag_q    <= '0;
         req_widx_q   <= '0;
         req_write_q  <= 1'b0;
         req_wdata_q  <= '0;
         req_be_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_write_q  <= 1'b0;
         cmd_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         line_valid_q <= line_valid_d;
         line_tag_q   <= line_tag_d;
         line_data_q  <= line_data_d;
         req_tag_q    <= req_tag_d;
         req_widx_q   <= req_widx_d;
         req_write_q  <= req_write_d;
         req_wdata_q  <= req_wdata_d;
         req_be_q     <= req_be_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_write_q  <= cmd_write_d;
         cmd_data_q   <= cmd_data_d;
      end
   end

endmodule

// File: tb/tb_sddr_line_adapter.sv
// Directed bench for the SDRAM line adapter with a hand-driven controller.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_sddr_line_adapter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int   hs_cnt = 0;
   int   rsp_cnt = 0;

   sddr_line_adapter_if bus ();

   sddr_line_adapter dut (
      .cpu_clock_i (clk),
      .reset_i     (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && bus.mem_cmd_valid && bus.mem_cmd_ack) hs_cnt++;
      if (bus.cpu_rsp_valid) rsp_cnt++;
   end

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cpu_send(input logic [26:0] a, input logic wr,
                           input logic [31:0] wd, input logic [3:0] be);
      @(negedge clk);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_addr  = a;
      bus.cpu_req_write = wr;
      bus.cpu_req_wdata = wd;
      bus.cpu_req_be    = be;
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
   endtask

   task automatic wait_cmd(input string tag);
      int n = 0;
      while (!bus.mem_cmd_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.mem_cmd_valid) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic serve(input string tag, input logic [26:0] ea,
                        input logic ew, input logic [127:0] ed,
                        input logic [127:0] line, input int hold,
                        input logic do_rsp);
      int bad = 0;
      wait_cmd(tag);
      check({tag, "_addr"}, 128'(bus.mem_cmd_addr), 128'(ea));
      check({tag, "_write"}, 128'(bus.mem_cmd_write), 128'(ew));
      if (ew) check({tag, "_data"}, bus.mem_cmd_data, ed);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (!bus.mem_cmd_valid || bus.mem_cmd_addr != ea ||
             bus.cpu_req_ack) bad++;
      end
      if (hold > 0) check({tag, "_stable"}, 128'(bad), 0);
      bus.mem_cmd_ack = 1'b1;
      @(negedge clk);
      bus.mem_cmd_ack = 1'b0;
      check({tag, "_drop"}, 128'(bus.mem_cmd_valid), 0);
      if (do_rsp) begin
         @(negedge clk);
         bus.mem_rsp_ready = 1'b1;
         bus.mem_rsp_data  = line;
         @(negedge clk);
         bus.mem_rsp_ready = 1'b0;
      end
   endtask

   // Latency counted in edges from the mem_rsp_ready sample edge.
   task automatic wait_rsp(input string tag, input logic [31:0] ed);
      int lat = 1;
      while (!bus.cpu_rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 128'(lat), 2);
      check({tag, "_rdata"}, 128'(bus.cpu_rsp_rdata), 128'(ed));
   endtask

   localparam logic [127:0] L1 = {32'hDDDDDDDD, 32'hCCCCCCCC,
                                  32'hBBBBBBBB, 32'hAAAAAAAA};
   localparam logic [127:0] L1W = {32'hDDDDDDDD, 32'hCC22CC44,
                                   32'hBBBBBBBB, 32'hAAAAAAAA};
   localparam logic [127:0] L2 = {32'h44444444, 32'h33333333,
                                  32'h22222222, 32'h11111111};
   localparam logic [127:0] L2W = {32'h44444444, 32'h33333333,
                                   32'h22222222, 32'hDEADBEEF};
   localparam logic [127:0] L3 = {32'h87654321, 32'h0BADF00D,
                                  32'h5A5A5A5A, 32'h01234567};

   initial begin
      int hs0;
      int r0;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_addr  = '0;
      bus.cpu_req_write = 1'b0;
      bus.cpu_req_wdata = '0;
      bus.cpu_req_be    = '0;
      bus.mem_cmd_ack   = 1'b0;
      bus.mem_rsp_ready = 1'b0;
      bus.mem_rsp_data  = '0;

      repeat (3) @(negedge clk);
      check("rst_rsp_valid", 128'(bus.cpu_rsp_valid), 0);
      check("rst_cmd_valid", 128'(bus.mem_cmd_valid), 0);
      check("rst_cmd_addr", 128'(bus.mem_cmd_addr), 0);
      check("rst_rdata", 128'(bus.cpu_rsp_rdata), 0);
      check("rst_ack", 128'(bus.cpu_req_ack), 1);
      rst = 1'b0;

      // Read miss then fill
      cpu_send(27'h10, 1'b0, 32'h0, 4'hF);
      check("rmiss_ack_busy", 128'(bus.cpu_req_ack), 0);
      serve("rmiss", 27'h10, 1'b0, '0, L1, 0, 1'b1);
      wait_rsp("rmiss", 32'hAAAAAAAA);

      // Read hit: 1 cycle, no controller traffic
      cpu_send(27'h14, 1'b0, 32'h0, 4'hF);
      check("rhit_valid", 128'(bus.cpu_rsp_valid), 1);
      check("rhit_rdata", 128'(bus.cpu_rsp_rdata), 128'(32'hBBBBBBBB));
      check("rhit_nocmd", 128'(bus.mem_cmd_valid), 0);

      // Partial write hit
      cpu_send(27'h18, 1'b1, 32'h11223344, 4'b0101);
      serve("whit", 27'h10, 1'b1, L1W, '0, 0, 1'b1);
      wait_rsp("whit", 32'hCC22CC44);
      cpu_send(27'h18, 1'b0, 32'h0, 4'hF);
      check("whit_readback", 128'(bus.cpu_rsp_rdata), 128'(32'hCC22CC44));

      // Write miss: fill then write-back, exactly two handshakes
      hs0 = hs_cnt;
      cpu_send(27'h1000, 1'b1, 32'hDEADBEEF, 4'hF);
      serve("wmiss_fill", 27'h1000, 1'b0, '0, L2, 0, 1'b1);
      serve("wmiss_wb", 27'h1000, 1'b1, L2W, '0, 0, 1'b1);
      wait_rsp("wmiss", 32'hDEADBEEF);
      check("wmiss_hs", 128'(hs_cnt - hs0), 2);

      // Controller stall of 20 cycles
      cpu_send(27'h2000, 1'b0, 32'h0, 4'hF);
      serve("stall", 27'h2000, 1'b0, '0, L2, 20, 1'b1);
      wait_rsp("stall", 32'h11111111);

      // Reset during FILL_WAIT, then stray burst-done
      cpu_send(27'h3000, 1'b0, 32'h0, 4'hF);
      serve("rst_fill", 27'h3000, 1'b0, '0, '0, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_cmd", 128'(bus.mem_cmd_valid), 0);
      check("rst_mid_ack", 128'(bus.cpu_req_ack), 1);
      r0 = rsp_cnt;
      bus.mem_rsp_ready = 1'b1;
      bus.mem_rsp_data  = L3;
      @(negedge clk);
      bus.mem_rsp_ready = 1'b0;
      repeat (4) @(negedge clk);
      check("stray_no_rsp", 128'(rsp_cnt - r0), 0);
      check("stray_no_cmd", 128'(bus.mem_cmd_valid), 0);
      cpu_send(27'h3000, 1'b0, 32'h0, 4'hF);
      check("refetch_cmd", 128'(bus.mem_cmd_valid), 1);
      serve("refetch", 27'h3000, 1'b0, '0, L3, 0, 1'b1);
      wait_rsp("refetch", 32'h01234567);

      // Read hit with a stale burst-done in IDLE
      @(negedge clk);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_addr  = 27'h3004;
      bus.cpu_req_write = 1'b0;
      bus.mem_rsp_ready = 1'b1;
      @(negedge clk);
      bus.cpu_req_valid = 1'b0;
      bus.mem_rsp_ready = 1'b0;
      check("stale_rdata", 128'(bus.cpu_rsp_rdata), 128'(32'h5A5A5A5A));
      check("stale_ack", 128'(bus.cpu_req_ack), 1);
      check("stale_nocmd", 128'(bus.mem_cmd_valid), 0);

      // be==0 write is a no-op
      cpu_send(27'h3008, 1'b1, 32'hFFFFFFFF, 4'h0);
      check("nop_valid", 128'(bus.cpu_rsp_valid), 1);
      check("nop_nocmd", 128'(bus.mem_cmd_valid), 0);
      cpu_send(27'h3008, 1'b0, 32'h0, 4'hF);
      check("nop_line", 128'(bus.cpu_rsp_rdata), 128'(32'h0BADF00D));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sddr_line_adapter.md
# sddr_line_adapter

- Upstream adapter in front of the DDR controller's data interface.
- Converts 32-bit CPU word accesses with byte enables into full-burst line transfers (BURST_LENGTH×DATA_BITS bits).
- Holds one line buffer that serves read hits, and performs read-modify-write on partial writes.
- Is the sole master of the controller's data interface.

## Interface
Parameters:
- BANK_BITS, 3, bank address bits
- ROW_BITS, 13, row address bits
- COL_BITS, 10, column address bits
- DATA_BITS, 16, DRAM data width
- BURST_LENGTH, 8, beats per burst
- Derived: LINE_BITS=BURST_LENGTH*DATA_BITS (128); LINE_BYTES=LINE_BITS/8; ADDRESS_BITS=BANK_BITS+ROW_BITS+COL_BITS+$clog2(DATA_BITS/8) (27, byte address). LINE_BITS must be a multiple of 32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- cpu_clock_i  in  1  clock
- reset_i  in  1  async active-high reset
- cpu_req_valid  in  1  request present
- cpu_req_ack  out  1  request accepted when valid&&ack at posedge
- cpu_req_addr  in  ADDRESS_BITS  byte address, bits[1:0] ignored
- cpu_req_write  in  1  1=write
- cpu_req_wdata  in  32  write data
- cpu_req_be  in  4  byte enables
- cpu_rsp_valid  out  1  one-cycle completion pulse, reads and writes
- cpu_rsp_rdata  out  32  read data, valid with cpu_rsp_valid
- mem_cmd_valid  out  1  to controller data_cmd_valid
- mem_cmd_ack  in  1  from controller data_cmd_ack
- mem_cmd_addr  out  ADDRESS_BITS  line-aligned address, low $clog2(LINE_BYTES) bits zero
- mem_cmd_write  out  1  burst write
- mem_cmd_data  out  LINE_BITS  write line
- mem_rsp_ready  in  1  one-cycle burst-done pulse, reads and writes
- mem_rsp_data  in  LINE_BITS  read line, sampled on mem_rsp_ready

## Operation
- Line buffer holds line_valid, line_tag (addr above line offset) and line_data. Word w = addr[$clog2(LINE_BYTES)-1:2] sits at line_data[32w+31:32w]. Byte lanes are little-endian.
- Hit = line_valid && tag match.
- cpu_req_ack = (state==IDLE), combinational.
- States:
  - IDLE:
    - read hit → cpu_rsp_valid next cycle, stay IDLE.
    - be==0 → no-op, rsp next cycle.
    - write hit → merge bytes into line_data → WB_REQ.
    - any miss → latch request → FILL_REQ.
  - FILL_REQ: mem_cmd_valid=1, write=0, addr=line address. On valid&&ack → FILL_WAIT.
  - FILL_WAIT: on mem_rsp_ready, load line_data/tag and set line_valid. Then:
    - pending read → RESP.
    - pending write → merge → WB_REQ.
  - WB_REQ: mem_cmd_valid=1, write=1, data=line_data. On handshake → WB_WAIT.
  - WB_WAIT: on mem_rsp_ready → RESP.
  - RESP: cpu_rsp_valid=1 for one cycle, rdata = the addressed word → IDLE.
- mem_cmd_valid holds until handshake. mem_cmd_addr/data are stable while valid.
- mem_rsp_ready outside FILL_WAIT/WB_WAIT is ignored.
- A write miss always fills first, even with be==4'hF.
- On a miss the line is replaced; it is never dirty, because writes are write-through.
- cpu_rsp_rdata for writes returns the merged word.

## Timing
- All outputs are registered except cpu_req_ack.
- Reset values: every output 0; state=IDLE; line_valid=0.
- Read hit latency: 1 cycle; back-to-back hits at 1/cycle.
- Read miss: rsp 2 cycles after the mem_rsp_ready sample edge (FILL_WAIT→RESP→pulse), plus controller latency.
- Write completes only after the controller's write-done pulse.
- Reset mid-operation:
  - Immediate return to IDLE; line invalidated; mem_cmd_valid dropped.
  - A later stray mem_rsp_ready is ignored.
- Simultaneous read hit accept and a stale mem_rsp_ready in IDLE: the pulse is ignored.

## Structure
- Shared package sddr_pkg holds:
  - state enum (IDLE, FILL_REQ, FILL_WAIT, WB_REQ, WB_WAIT, RESP);
  - line width/offset localparams derived from the controller parameters;
  - function merge_word(line, word_idx, wdata, be).
- No sub-module; a single module of about 200 lines.

## Test plan
- After reset, read 0x0000010 → FILL_REQ with mem_cmd_addr=0x0000010. Model returns line 0x...DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA → rdata=0xAAAAAAAA, line_valid=1.
- Then read 0x0000014 → no mem_cmd_valid; rdata=0xBBBBBBBB exactly 1 cycle after accept.
- Write 0x0000018, wdata=0x11223344, be=4'b0101 on a hit → one burst write of the line with word2=0xCC22CC44. cpu_rsp_valid comes 2 cycles after the write-done pulse.
- Write miss to 0x0001000, be=4'hF → fill read then write burst in that order; exactly two mem handshakes.
- Assert reset_i in FILL_WAIT, then drive mem_rsp_ready → no rsp; next read of the same address refetches.
- Hold mem_cmd_ack=0 for 20 cycles → mem_cmd_valid/addr stable; cpu_req_ack=0 throughout.
